// File: rtl/less_than_msb_serial_pkg.sv
// Shared ALU constants for the serial less-than unit: FSM encoding,
// default digit width and the opcodes that select signed/unsigned compare.
package less_than_msb_serial_pkg;

    // FSM state encoding (2 bits)
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Bits compared per scan cycle unless overridden
    localparam int DEFAULT_DIGIT = 4;

    // ALU opcodes; ALU_SLT drives signed_i=1, ALU_SLTU drives signed_i=0
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;

    // Index counter width for a given number of digits, never below 1
    function automatic int idx_width(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage

// File: rtl/less_than_msb_serial_cmp.sv
// One-digit unsigned comparator: equality and strict less-than.
module lt_digit_cmp #(
    parameter int W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         eq_o,
    output logic         lt_o
);

    // Pure combinational compare of the selected digit pair
    always_comb begin
        eq_o = (a_i == b_i);
        lt_o = (a_i < b_i);
    end

endmodule

// File: rtl/less_than_msb_serial.sv
// Serial SLT/SLTU: scans operands MSB-first one digit per cycle and stops at
// the first unequal digit. Signed compare is done by flipping both MSBs at
// accept time so the scan itself is always unsigned.
module less_than_msb_serial
    import less_than_msb_serial_pkg::*;
#(
    parameter int N     = 32,
    parameter int DIGIT = DEFAULT_DIGIT
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         signed_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [N-1:0] r_o
);

    localparam int NDIG  = N / DIGIT;
    localparam int IDX_W = idx_width(NDIG);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NDIG - 1);

    logic [1:0]       state_q, state_d;
    logic [N-1:0]     a_q, a_d;
    logic [N-1:0]     b_q, b_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             lt_q, lt_d;

    logic             dig_eq, dig_lt;

    lt_digit_cmp #(.W(DIGIT)) u_cmp (
        .a_i  (a_q[idx_q*DIGIT +: DIGIT]),
        .b_i  (b_q[idx_q*DIGIT +: DIGIT]),
        .eq_o (dig_eq),
        .lt_o (dig_lt)
    );

    // Next-state, operand capture and digit-index countdown
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        lt_d    = lt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid_i) begin
                    // Bias MSB so two's-complement order becomes unsigned order
                    a_d        = a_i;
                    b_d        = b_i;
                    a_d[N-1]   = a_i[N-1] ^ signed_i;
                    b_d[N-1]   = b_i[N-1] ^ signed_i;
                    idx_d      = IDX_TOP;
                    lt_d       = 1'b0;
                    state_d    = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (!dig_eq) begin
                    lt_d    = dig_lt;
                    state_d = ST_DONE;
                end else if (idx_q == '0) begin
                    lt_d    = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q - 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers, async reset aborts any op in flight
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            lt_q    <= lt_d;
        end
    end

    // Handshake outputs; result is zero outside DONE, upper bits always zero
    always_comb begin
        in_ready_o  = (state_q == ST_IDLE);
        out_valid_o = (state_q == ST_DONE);
        r_o         = '0;
        r_o[0]      = (state_q == ST_DONE) && lt_q;
    end

endmodule

// File: tb/tb_less_than_msb_serial.sv
// Bench for less_than_msb_serial: a cycle-level behavioural model (busy flag,
// cycles-to-result countdown, expected result from plain signed/unsigned
// arithmetic) checked every cycle, plus directed literal expectations.
module tb_less_than_msb_serial;
    import less_than_msb_serial_pkg::*;

    localparam int N    = 32;
    localparam int DIG  = 4;
    localparam int NDIG = N / DIG;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready_o;
    logic [N-1:0] a_i = '0;
    logic [N-1:0] b_i = '0;
    logic         signed_i = 1'b0;
    logic         out_valid_o;
    logic         out_ready = 1'b0;
    logic [N-1:0] r_o;

    int checks = 0;
    int errors = 0;

    less_than_msb_serial #(.N(N), .DIGIT(DIG)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .signed_i    (signed_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready),
        .r_o         (r_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic ref_lt(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
        if (s) return $signed(a) < $signed(b);
        return a < b;
    endfunction

    // Digits the MSB-first scan must look at: up to and including the first differing one
    function automatic int digits_scanned(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] x;
        x = a ^ b;
        for (int d = NDIG - 1; d >= 0; d--)
            if (((x >> (d * DIG)) & ((1 << DIG) - 1)) != 0) return NDIG - d;
        return NDIG;
    endfunction

    // Behavioural model: busy between accept and output handshake, result appears after k edges
    logic m_busy = 1'b0;
    int   m_rem  = 0;
    logic m_r    = 1'b0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_rem  <= 0;
            m_r    <= 1'b0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy <= 1'b1;
                m_rem  <= digits_scanned(a_i, b_i);
                m_r    <= ref_lt(a_i, b_i, signed_i);
            end
        end else if (m_rem > 0) begin
            m_rem <= m_rem - 1;
        end else if (out_ready) begin
            m_busy <= 1'b0;
        end
    end

    // Per-cycle compare of all outputs against the model
    always @(negedge clk) begin
        chk("in_ready", {31'd0, in_ready_o}, {31'd0, !m_busy});
        chk("out_valid", {31'd0, out_valid_o}, {31'd0, m_busy && m_rem == 0});
        chk("r_o", r_o, (m_busy && m_rem == 0) ? {31'd0, m_r} : 32'd0);
    end

    // Issue one op, wait for the result, optionally stall the consumer with ignored input pulses.
    // Starts and ends #1 after a rising edge.
    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                         input int stall, input logic pulse,
                         output logic [N-1:0] r, output int lat);
        bit acc;
        a_i = a; b_i = b; signed_i = s; in_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 60 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready_o;
            @(posedge clk);
        end
        #1 in_valid = 1'b0;
        if (!acc) chk("accept_timeout", 0, 1);
        lat = 1;
        r = 'x;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid_o) break;
            @(posedge clk);
            lat++;
        end
        if (!out_valid_o) chk("result_timeout", 0, 1);
        r = r_o;
        for (int i = 0; i < stall; i++) begin
            if (pulse) begin
                in_valid = i[0];
                a_i = 32'd0; b_i = 32'd1; signed_i = 1'b0;
            end
            @(posedge clk);
            #1 chk("stall_r_stable", r_o, r);
            chk("stall_valid", {31'd0, out_valid_o}, 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    logic [N-1:0] r;
    int           lat;
    logic [N-1:0] ra, rb;
    logic         rs;

    initial begin
        #1 rst = 1'b1;
        #1 chk("rst_in_ready", {31'd0, in_ready_o}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
        chk("rst_r", r_o, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Pin the model itself
        chk("model_slt_min", {31'd0, ref_lt(32'h8000_0000, 32'h7FFF_FFFF, 1'b1)}, 32'd1);
        chk("model_sltu_min", {31'd0, ref_lt(32'h8000_0000, 32'h7FFF_FFFF, 1'b0)}, 32'd0);
        chk("model_k_eq", digits_scanned(32'hDEAD_BEEF, 32'hDEAD_BEEF), NDIG);
        chk("model_k_msb", digits_scanned(32'hF000_0000, 32'h1000_0000), 1);

        do_op(32'h0000_0001, 32'h0000_0002, (ALU_SLTU == ALU_SLT), 0, 0, r, lat);
        chk("t1_r", r, 32'd1);       chk("t1_lat", lat, 9);
        do_op(32'hF000_0000, 32'h1000_0000, 1'b0, 0, 0, r, lat);
        chk("t2_r", r, 32'd0);       chk("t2_lat", lat, 2);
        do_op(32'h8000_0000, 32'h7FFF_FFFF, (ALU_SLT == ALU_SLT), 0, 0, r, lat);
        chk("t3_slt_r", r, 32'd1);   chk("t3_slt_lat", lat, 2);
        do_op(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 0, 0, r, lat);
        chk("t3_sltu_r", r, 32'd0);
        do_op(32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 0, 0, r, lat);
        chk("t3_sltu_rev_r", r, 32'd1);
        do_op(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 0, 0, r, lat);
        chk("t4_s_r", r, 32'd0);     chk("t4_s_lat", lat, 9);
        do_op(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 0, 0, r, lat);
        chk("t4_u_r", r, 32'd0);     chk("t4_u_lat", lat, 9);

        // Consumer stall with ignored input pulses, then a fresh op
        do_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 5, 1, r, lat);
        chk("t5_r", r, 32'd1);
        do_op(32'h0000_0010, 32'h0000_0020, 1'b0, 0, 0, r, lat);
        chk("t5_next_r", r, 32'd1);  chk("t5_next_lat", lat, 8);

        // Reset in the middle of a scan
        a_i = 32'd5; b_i = 32'd5; signed_i = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1 chk("t6_out_valid", {31'd0, out_valid_o}, 32'd0);
        chk("t6_r", r_o, 32'd0);
        chk("t6_in_ready", {31'd0, in_ready_o}, 32'd1);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        do_op(32'd3, 32'd5, 1'b0, 0, 0, r, lat);
        chk("t6_next_r", r, 32'd1);

        // Randomized ops: fully random, equal, or differing in one random digit
        for (int n = 0; n < 60; n++) begin
            ra = $urandom;
            case ($urandom_range(0, 2))
                0: rb = $urandom;
                1: rb = ra;
                default: rb = ra ^ (N'($urandom_range(1, (1 << DIG) - 1)) << (DIG * $urandom_range(0, NDIG - 1)));
            endcase
            rs = $urandom_range(0, 1);
            do_op(ra, rb, rs, $urandom_range(0, 3), $urandom_range(0, 1), r, lat);
            chk("rnd_r", r, {31'd0, ref_lt(ra, rb, rs)});
            chk("rnd_lat", lat, digits_scanned(ra, rb) + 1);
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
